// File: rtl/matdet4_seq.sv
// -----------------------------------------------------------------------------
// matdet4_seq
//
// Sequential 4x4 determinant engine. Expands the determinant along row 0 and
// evaluates one cofactor per clock through a single shared combinational 3x3
// determinant stage, accumulating with alternating sign. All arithmetic wraps
// modulo 2^DATA_WIDTH.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   producer offers a matrix on a
//   in_ready   out  engine can accept (IDLE and not in reset)
//   a          in   row-major 4x4 matrix, element (r,c) at (4r+c)*DATA_WIDTH
//   out_valid  out  det holds a completed result
//   out_ready  in   consumer accepts det
//   det        out  registered determinant result
//   busy       out  engine is computing or holding a result
// -----------------------------------------------------------------------------
module matdet4_seq #(
  parameter int DATA_WIDTH  = 32,
  parameter int MATRIX_SIZE = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [MATRIX_SIZE*DATA_WIDTH-1:0] a,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_WIDTH-1:0]             det,
  output logic                              busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_COF  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  logic [1:0]            r_j;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0] r_det;
  logic                  r_out_valid;
  logic                  r_busy;
  logic [DATA_WIDTH-1:0] r_m [MATRIX_SIZE];

  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_minor [9];
  logic [DATA_WIDTH-1:0] w_c0;
  logic [DATA_WIDTH-1:0] w_c1;
  logic [DATA_WIDTH-1:0] w_c2;
  logic [DATA_WIDTH-1:0] w_det3;
  logic [DATA_WIDTH-1:0] w_term;
  logic [DATA_WIDTH-1:0] w_acc_next;

  assign in_ready  = !r_busy && !rst;
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign det       = r_det;

  // Matrix register file, loaded only on accept.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int k = 0; k < MATRIX_SIZE; k++) begin
        r_m[k] <= a[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Minor for column j: rows 1..3, columns at or beyond j shift right by one
  // to skip the removed column.
  generate
    for (genvar gi = 0; gi < 9; gi++) begin : g_minor
      localparam int         ROW  = gi / 3 + 1;
      localparam logic [1:0] COL  = 2'(gi % 3);
      localparam int         BASE = ROW * 4 + gi % 3;
      assign w_minor[gi] = (COL >= r_j) ? r_m[BASE + 1] : r_m[BASE];
    end
  endgenerate

  // Shared 3x3 determinant: first-row expansion over 2x2 minors.
  assign w_c0   = w_minor[4] * w_minor[8] - w_minor[5] * w_minor[7];
  assign w_c1   = w_minor[3] * w_minor[8] - w_minor[5] * w_minor[6];
  assign w_c2   = w_minor[3] * w_minor[7] - w_minor[4] * w_minor[6];
  assign w_det3 = w_minor[0] * w_c0 - w_minor[1] * w_c1 + w_minor[2] * w_c2;

  assign w_term     = r_m[{2'b00, r_j}] * w_det3;
  // Odd columns carry a negative cofactor sign.
  assign w_acc_next = r_j[0] ? (r_acc - w_term) : (r_acc + w_term);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_j         <= 2'd0;
      r_acc       <= '0;
      r_det       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_acc   <= '0;
            r_j     <= 2'd0;
            r_busy  <= 1'b1;
            r_state <= S_COF;
          end
        end
        S_COF: begin
          r_acc <= w_acc_next;
          r_j   <= r_j + 2'd1;
          if (r_j == 2'd3) begin
            r_det       <= w_acc_next;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
